// File: rtl/sub_pkg.sv
// sub_pkg: widths and per-stage record for pipelined_subtractor; SUB_OVF_EN adds the sign-tracking fields
package sub_pkg;
  localparam int WIDTH   = 16;
  localparam int SLICE_W = 4;
  localparam int NSLICE  = WIDTH / SLICE_W;
  typedef struct packed {
    logic             valid;
    logic             borrow;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_OVF_EN
    logic             sa;
    logic             sb;
`endif
  } stage_t;
endpackage

// File: rtl/sub_select_slice.sv
// sub_select_slice: 4-bit subtract computed for both borrow-in values, then selected by the incoming borrow
module sub_select_slice
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);
  logic [SLICE_W:0] r0, r1;
  // a + ~b + carry for carry=1 (no borrow in) and carry=0 (borrow in); borrow out is the inverted carry
  always_comb begin
    r0   = {1'b0, a} + {1'b0, ~b} + (SLICE_W+1)'(1);
    r1   = {1'b0, a} + {1'b0, ~b};
    d    = bin ? r1[SLICE_W-1:0] : r0[SLICE_W-1:0];
    bout = bin ? ~r1[SLICE_W] : ~r0[SLICE_W];
  end
endmodule

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: 4-stage 16-bit D = A - B - bin with borrow-out, one 4-bit slice per stage; SUB_OVF_EN adds signed overflow output ovf
module pipelined_subtractor
  import sub_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  stage_t src  [NSLICE];
  stage_t st_d [NSLICE];
  stage_t st_q [NSLICE];
  logic [NSLICE-1:0][SLICE_W-1:0] sd;
  logic [NSLICE-1:0]              sbo;
  logic                           en;
  assign en       = !st_q[NSLICE-1].valid || out_ready;
  assign in_ready = en;
  // each stage consumes the record of the stage before it; stage 0 consumes the input port
  always_comb begin
    src[0]        = '0;
    src[0].valid  = in_valid;
    src[0].borrow = bin;
    src[0].a      = A;
    src[0].b      = B;
`ifdef SUB_OVF_EN
    src[0].sa     = A[WIDTH-1];
    src[0].sb     = B[WIDTH-1];
`endif
    for (int k = 1; k < NSLICE; k++) src[k] = st_q[k-1];
  end
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    sub_select_slice u_slice (
      .a   (src[i].a[SLICE_W-1:0]),
      .b   (src[i].b[SLICE_W-1:0]),
      .bin (src[i].borrow),
      .d   (sd[i]),
      .bout(sbo[i])
    );
  end
  // new difference nibble enters at the top of D; low operand nibble is consumed and the rest shifts down
  always_comb begin
    for (int k = 0; k < NSLICE; k++) begin
      st_d[k]        = src[k];
      st_d[k].borrow = sbo[k];
      st_d[k].d      = {sd[k], src[k].d[WIDTH-1:SLICE_W]};
      st_d[k].a      = src[k].a >> SLICE_W;
      st_d[k].b      = src[k].b >> SLICE_W;
    end
  end
  // whole pipeline advances together, bubbles included, and holds while the output is stalled
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) for (int k = 0; k < NSLICE; k++) st_q[k] <= '0;
    else if (en) st_q <= st_d;
  assign D         = st_q[NSLICE-1].d;
  assign bout      = st_q[NSLICE-1].borrow;
  assign out_valid = st_q[NSLICE-1].valid;
`ifdef SUB_OVF_EN
  assign ovf = (st_q[NSLICE-1].sa != st_q[NSLICE-1].sb) && (st_q[NSLICE-1].d[WIDTH-1] != st_q[NSLICE-1].sa);
`endif
endmodule

// File: tb/tb_pipelined_subtractor.sv
// tb_pipelined_subtractor: randomized and directed checks of pipelined_subtractor against an arithmetic reference; honours SUB_OVF_EN
module tb_pipelined_subtractor;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] A, B, D;
  logic        bin, in_valid, in_ready, bout, out_valid, out_ready;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int n_in = 0;
  int n_out = 0;
  bit          mv [4];
  logic [16:0] md [4];
  bit          mo [4];

  pipelined_subtractor dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .A        (A),
    .B        (B),
    .bin      (bin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .D        (D),
    .bout     (bout),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0;
      md[i] = '0;
      mo[i] = 0;
    end
  endtask

  // one clock cycle, entered and left at a falling edge; the model is a 4-slot delay line of arithmetic results
  task automatic cycle(input bit iv, input logic [15:0] a, input logic [15:0] b, input bit bi, input bit ordy);
    bit          adv;
    logic [16:0] r;
    in_valid  = iv;
    A         = a;
    B         = b;
    bin       = bi;
    out_ready = ordy;
    #1;
    adv = !mv[3] || ordy;
    chk("in_ready", in_ready, adv);
    chk("out_valid", out_valid, mv[3]);
    if (mv[3]) begin
      chk("D", D, md[3][15:0]);
      chk("bout", bout, md[3][16]);
`ifdef SUB_OVF_EN
      chk("ovf", ovf, mo[3]);
`endif
    end
    @(posedge Clk);
    if (adv) begin
      if (mv[3]) n_out++;
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
        mo[i] = mo[i-1];
      end
      r     = {1'b0, a} - {1'b0, b} - 17'(bi);
      mv[0] = iv;
      md[0] = r;
      mo[0] = (a[15] != b[15]) && (r[15] != a[15]);
      if (iv) n_in++;
    end
    @(negedge Clk);
  endtask

  // single op on an empty pipe: absent one edge early, present with fixed values after the third edge
  task automatic directed(input logic [15:0] a, input logic [15:0] b, input bit bi,
                          input logic [15:0] exp_d, input bit exp_b, input bit exp_o);
    cycle(1, a, b, bi, 1);
    cycle(0, 16'h0, 16'h0, 0, 1);
    cycle(0, 16'h0, 16'h0, 0, 1);
    chk("lat_early", out_valid, 0);
    cycle(0, 16'h0, 16'h0, 0, 0);
    chk("lat_valid", out_valid, 1);
    chk("dir_D", D, exp_d);
    chk("dir_bout", bout, exp_b);
`ifdef SUB_OVF_EN
    chk("dir_ovf", ovf, exp_o);
`else
    if (exp_o) n_chk += 0;
`endif
    cycle(0, 16'h0, 16'h0, 0, 1);
  endtask

  initial begin
    Reset     = 1'b1;
    A         = '0;
    B         = '0;
    bin       = 0;
    in_valid  = 0;
    out_ready = 0;
    model_clear();
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_D", D, 16'h0000);
    chk("rst_bout", bout, 0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    Reset = 1'b0;

    directed(16'h0005, 16'h0003, 0, 16'h0002, 0, 0);
    directed(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0);
    directed(16'h1000, 16'h0000, 1, 16'h0FFF, 0, 0);
    directed(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1);
    directed(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1);
    directed(16'h0000, 16'h0000, 1, 16'hFFFF, 1, 0);

    // four back-to-back ops, output stalled two cycles once the first result shows
    for (int i = 0; i < 4; i++) cycle(1, 16'(1000 * (i + 1)), 16'(7 * i + 3), 1'(i), 1);
    chk("stall_first", out_valid, 1);
    chk("stall_first_D", D, 16'd997);
    cycle(1, 16'hAAAA, 16'h5555, 1, 0);
    chk("stall_hold_D", D, 16'd997);
    chk("stall_in_ready", in_ready, 0);
    cycle(1, 16'h1234, 16'h4321, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 16'h0, 0, 1);
    chk("stall_count", n_out, n_in);

    // asynchronous reset in the middle of a low phase with two ops in flight
    cycle(1, 16'h0F0F, 16'h0101, 0, 1);
    cycle(1, 16'h2222, 16'h1111, 1, 1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_D", D, 16'h0000);
    chk("arst_bout", bout, 0);
    model_clear();
    n_in  = 0;
    n_out = 0;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 16'($urandom), 16'($urandom), 1'($urandom), 1);
      chk("post_rst_idle", out_valid, 0);
    end
    directed(16'h0100, 16'h0001, 0, 16'h00FF, 0, 0);

    // random traffic with random back-pressure
    n_in  = 0;
    n_out = 0;
    for (int c = 0; c < 60000 && n_in < 10000; c++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    chk("rand_accepted", n_in, 10000);
    for (int i = 0; i < 8; i++) cycle(0, 16'h0, 16'h0, 0, 1);
    chk("rand_drained", n_out, n_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_subtractor.md
# pipelined_subtractor

Four-stage pipelined 16-bit subtractor computing D = A − B − bin with borrow-out, one 4-bit carry-select slice per stage. It is the subtract-direction companion to the team's 16-bit carry-select adder and is used by datapaths that need a full-rate difference stream under valid/ready flow control. Throughput is one operation per cycle, with a fixed 4-cycle latency.

## Interface
Parameters:
- none; widths are fixed by package constants (WIDTH=16, SLICE_W=4).

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- A  in  16  minuend.
- B  in  16  subtrahend.
- bin  in  1  borrow-in.
- in_valid  in  1  operands present.
- in_ready  out  1  pipeline can accept this cycle.
- D  out  16  difference, (A − B − bin) mod 2^16.
- bout  out  1  borrow-out; 1 iff unsigned A < B + bin.
- out_valid  out  1  D/bout valid.
- out_ready  in  1  downstream accepts result.
- ovf  out  1  signed overflow (only with SUB_OVF_EN).

## Operation
- Each slice computes A_s − B_s for borrow-in 0 and for borrow-in 1 in parallel, then selects with the incoming registered borrow. The 4-bit difference is A_s + ~B_s + carry, with carry = ~borrow.
- Stage k (k = 1..4) computes slice k−1 (bits 4k−1 : 4k−4). Stage k registers:
  - the borrow out of slice k−1;
  - all difference bits produced so far;
  - the operand bits not yet consumed;
  - a valid bit.
- Global advance enable: en = !out_valid || out_ready. in_ready = en.
- When en is high, every stage shifts forward one position and stage 1 loads (in_valid, A, B, bin). When en is low, every stage holds.
- An input transfer occurs on an edge where in_valid && in_ready. An output transfer occurs on an edge where out_valid && out_ready.
- Bubbles are not collapsed. An empty stage advances like a full one, and its valid bit stays 0.
- Order is strictly preserved, with no drop and no duplication.
- Reset values:
  - all valid bits 0, so out_valid=0 and in_ready=1;
  - all data registers 0, so D=0x0000, bout=0, and ovf=0.
- Reset mid-operation discards all in-flight operations. After release, nothing emerges until new inputs are accepted.
- Wrap-around: D is always taken modulo 2^16. bout reports the unsigned underflow.

## Timing
- Latency: an operand accepted on edge N appears with out_valid=1 after edge N+3. The pipeline registers are the last stage; there is no output combinational path from A/B.
- in_ready depends combinationally on out_ready and out_valid only. There is no path from in_valid to in_ready.
- While out_valid && !out_ready:
  - D, bout, ovf and out_valid hold stable;
  - in_ready=0;
  - input data is ignored.
- Simultaneous input and output transfer on the same edge is legal and sustains 1 op/cycle.

## Configuration
- SUB_OVF_EN defined:
  - adds port ovf, carried in the final stage;
  - ovf = (A[15] != B[15]) && (D[15] != A[15]), where A[15] and B[15] are the sign bits carried alongside the operation;
  - ovf holds with the other outputs during stall.
- SUB_OVF_EN undefined: no ovf port and no sign-tracking registers. D, bout and handshake behaviour are identical.

## Structure
- Package sub_pkg holds:
  - WIDTH=16, SLICE_W=4, NSLICE=WIDTH/SLICE_W;
  - a typedef for the per-stage register record (valid, borrow, partial D, remaining A/B, sign bits).
- One sub-module: sub_select_slice, a 4-bit dual-borrow ripple subtract with output select. Ports are a, b [3:0], bin, d [3:0], bout. It is instantiated four times, once per stage.
- The top level contains only the stage registers, the enable logic and the output mapping.

## Test plan
- 0x0005 − 0x0003, bin=0, out_ready=1 → D=0x0002, bout=0, out_valid rises after accept edge +3.
- 0x0000 − 0x0001, bin=0 → D=0xFFFF, bout=1. Also 0x1000 − 0x0000, bin=1 → D=0x0FFF, bout=0, which exercises borrow across all slices.
- With SUB_OVF_EN: 0x8000 − 0x0001 → D=0x7FFF, ovf=1, bout=0. Also 0x7FFF − 0xFFFF → D=0x8000, ovf=1, bout=1.
- Stream 4 back-to-back ops with out_ready held low for 2 cycles when the first result appears → outputs stable, in_ready=0 during the stall, all 4 results emerge in order with none lost.
- Reset asserted asynchronously mid-cycle with 2 ops in flight → out_valid=0, D=0, in_ready=1 immediately; no result appears after release until a new input is accepted.
- Random 10k ops with random in_valid/out_ready → every result matches a reference model of (A − B − bin) and the borrow, in order.
